// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy, terminal-count and wrap pulse.
// Define GRAY_COUNTER_CHECK_EN to add the sticky `err` self-check output.
module gray_counter #(
  parameter int unsigned          WIDTH     = 8,
  parameter bit                   SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc,
  output logic             wrapped
`ifdef GRAY_COUNTER_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrapped_d;
  logic             wrapped_q;
  logic             at_max;
  logic             at_zero;

  assign at_max  = &bin_q;
  assign at_zero = ~|bin_q;

  assign tc      = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));
  assign wrapped = wrapped_q;

  always_comb begin
    bin_d     = bin_q;
    wrapped_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (!at_max) begin
          bin_d = bin_q + WIDTH'(1);
        end else if (!SATURATE) begin
          bin_d     = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          bin_d = bin_q - WIDTH'(1);
        end else if (!SATURATE) begin
          bin_d     = '1;
          wrapped_d = 1'b1;
        end
      end
    end
    // Encode the next value so both codes update on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= RESET_VAL;
      gray_q    <= RESET_GRAY;
      wrapped_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef GRAY_COUNTER_CHECK_EN
  // skip_q marks cycles whose gray step came from rst/load and may jump arbitrarily.
  logic [WIDTH-1:0] gray_prev_q;
  logic [WIDTH-1:0] gray_diff;
  logic             skip_q;
  logic             multi_bit;
  logic             enc_bad;
  logic             err_d;
  logic             err_q;

  assign gray_diff = gray_q ^ gray_prev_q;
  assign multi_bit = |(gray_diff & (gray_diff - WIDTH'(1)));
  assign enc_bad   = gray_q != (bin_q ^ (bin_q >> 1));
  assign err       = err_q;

  always_comb begin
    err_d = err_q | (~skip_q & multi_bit) | enc_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      skip_q      <= 1'b1;
      gray_prev_q <= RESET_GRAY;
    end else begin
      err_q       <= err_d;
      skip_q      <= load;
      gray_prev_q <= gray_q;
    end
  end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a wrapping and a saturating instance driven by shared directed vectors.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;

  logic [7:0] bin0, gray0, bin1, gray1;
  logic       tc0, tc1, wr0, wr1;
`ifdef GRAY_COUNTER_CHECK_EN
  logic       err0, err1;
`endif

  gray_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'h00)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_q(bin0), .gray_q(gray0), .tc(tc0), .wrapped(wr0)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(err0)
`endif
  );

  gray_counter #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL(8'h00)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_q(bin1), .gray_q(gray1), .tc(tc1), .wrapped(wr1)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(err1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       sel;
    bit       chk_tc;
    bit       tc;
    bit       chk_st;
    bit [7:0] bin;
    bit [7:0] gray;
    bit       wr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit       prev_vld = 1'b0;
  bit [7:0] prev_bin, prev_gray;
  bit       prev_wr;
  bit       cur_sel = 1'b0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] b, g;
      logic       t, w;
      e = sb.pop_front();
      b = e.sel ? bin1 : bin0;
      g = e.sel ? gray1 : gray0;
      t = e.sel ? tc1 : tc0;
      w = e.sel ? wr1 : wr0;
      if (e.chk_tc) cmp("tc", {7'd0, t}, {7'd0, e.tc});
      if (e.chk_st) begin
        cmp("bin_q", b, e.bin);
        cmp("gray_q", g, e.gray);
        cmp("wrapped", {7'd0, w}, {7'd0, e.wr});
      end
`ifdef GRAY_COUNTER_CHECK_EN
      cmp("err", {7'd0, e.sel ? err1 : err0}, 8'd0);
`endif
    end
  end

  // Apply one vector; tc_x is expected before the edge, the rest after it.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input bit [7:0] lv,
                      input bit ctc, input bit tc_x,
                      input bit [7:0] bin_x, input bit [7:0] gray_x, input bit wr_x);
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; en = e; up_dn = u; load = l; load_val = lv;
    x.sel = cur_sel; x.chk_tc = ctc; x.tc = tc_x;
    x.chk_st = prev_vld; x.bin = prev_bin; x.gray = prev_gray; x.wr = prev_wr;
    sb.push_back(x);
    prev_vld = 1'b1; prev_bin = bin_x; prev_gray = gray_x; prev_wr = wr_x;
  endtask

  initial begin
    // Wrapping instance: reset, count up, wrap both ways, load priority, direction change, mid-count reset.
    cur_sel = 1'b0;
    step(1,1,1,0,8'h00, 0,0, 8'h00,8'h00,0);
    step(1,1,1,0,8'h00, 1,0, 8'h00,8'h00,0);
    step(0,1,1,0,8'h00, 1,0, 8'h01,8'h01,0);
    step(0,1,1,0,8'h00, 1,0, 8'h02,8'h03,0);
    step(0,1,1,0,8'h00, 1,0, 8'h03,8'h02,0);
    step(0,1,1,0,8'h00, 1,0, 8'h04,8'h06,0);
    step(0,1,1,0,8'h00, 1,0, 8'h05,8'h07,0);
    step(0,0,1,1,8'hFE, 1,0, 8'hFE,8'h81,0);
    step(0,1,1,0,8'h00, 1,0, 8'hFF,8'h80,0);
    step(0,1,1,0,8'h00, 1,1, 8'h00,8'h00,1);
    step(0,0,1,0,8'h00, 1,0, 8'h00,8'h00,0);
    step(0,1,0,0,8'h00, 1,1, 8'hFF,8'h80,1);
    step(0,0,0,1,8'h10, 1,0, 8'h10,8'h18,0);
    step(0,1,0,1,8'h55, 1,0, 8'h55,8'h7F,0);
    step(0,1,0,0,8'h00, 1,0, 8'h54,8'h7E,0);
    step(0,1,1,0,8'h00, 1,0, 8'h55,8'h7F,0);
    step(1,1,1,0,8'h00, 1,0, 8'h00,8'h00,0);
    step(0,1,1,0,8'h00, 1,0, 8'h01,8'h01,0);
    step(0,0,1,0,8'h00, 1,0, 8'h01,8'h01,0);

    // Saturating instance: hold at both terminals, then reset from saturation.
    cur_sel  = 1'b1;
    prev_vld = 1'b0;
    step(0,0,1,1,8'hFF, 1,0, 8'hFF,8'h80,0);
    step(0,1,1,0,8'h00, 1,1, 8'hFF,8'h80,0);
    step(0,1,1,0,8'h00, 1,1, 8'hFF,8'h80,0);
    step(0,1,1,0,8'h00, 1,1, 8'hFF,8'h80,0);
    step(0,0,0,1,8'h00, 1,0, 8'h00,8'h00,0);
    step(0,1,0,0,8'h00, 1,1, 8'h00,8'h00,0);
    step(0,0,1,1,8'hFF, 1,0, 8'hFF,8'h80,0);
    step(1,1,1,0,8'h00, 1,1, 8'h00,8'h00,0);
    step(0,0,1,0,8'h00, 1,0, 8'h00,8'h00,0);
    step(0,0,1,0,8'h00, 0,0, 8'h00,8'h00,0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
